// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
// Frame layout after the start bit: 8 data bits LSB first, odd parity, stop.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_e;

    typedef logic [7:0] byte_t;

    localparam int PAR_BIT    = 8;
    localparam int STOP_BIT   = 9;
    localparam int FRAME_BITS = 10;

    localparam int ERR_PARITY   = 0;
    localparam int ERR_FRAME    = 1;
    localparam int ERR_TIMEOUT  = 2;
    localparam int ERR_OVERFLOW = 3;
    localparam int ERR_W        = 4;

    // Data plus parity must hold an odd number of ones.
    function automatic logic parity_ok(input logic [PAR_BIT:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// First-word-fall-through byte FIFO; rdata shows the head (0 when empty), pop visible next cycle.
// A write while full is honoured only when paired with a read; otherwise it is dropped.
module ps2_byte_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr,
    input  byte_t                  wdata,
    input  logic                   rd,
    output byte_t                  rdata,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    byte_t          mem_q [DEPTH];
    logic [AW-1:0]  wptr_q, rptr_q;
    logic [CW-1:0]  count_q;
    logic           do_rd, do_wr;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign do_rd = rd & ~empty;
    assign do_wr = wr & (~full | do_rd);
    assign rdata = empty ? 8'h00 : mem_q[rptr_q];
    assign count = count_q;

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wptr_q] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_wr) wptr_q <= wptr_q + AW'(1);
            if (do_rd) rptr_q <= rptr_q + AW'(1);
            unique case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 receiver: sync, glitch filter, 11-bit frame check, FWFT byte FIFO, sticky error flags.
// Byte visible two cycles after the stop-bit strobe; with the FIFO full and no pop, good bytes are dropped.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 32767,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        samplen,
    input  logic                        ps2_clk,
    input  logic                        ps2_data,
    input  logic                        rden,
    input  logic                        clr_err,
    output logic [7:0]                  q,
    output logic                        dsr,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        parity_err,
    output logic                        frame_err,
    output logic                        timeout,
    output logic                        overflow
);
    logic [1:0]            clk_sync_q, dat_sync_q;
    logic                  filt_q, bit_stb_q;
    logic [3:0]            fcnt_q;
    state_e                state_q;
    logic [3:0]            bitcnt_q;
    logic [FRAME_BITS-1:0] shreg_q;
    logic [15:0]           wdog_q;
    logic                  push_q, par_fail_q, frm_fail_q;
    logic [ERR_W-1:0]      err_q, err_set;
    logic [FRAME_BITS-1:0] frame_nx;
    logic                  last_bit, to_evt, fifo_empty, fifo_full;

    // Sync and filter; the pins idle high, so the filtered level starts high.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filt_q     <= 1'b1;
            fcnt_q     <= '0;
            bit_stb_q  <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_data};
            bit_stb_q  <= 1'b0;
            if (samplen) begin
                if (clk_sync_q[1] == filt_q) begin
                    fcnt_q <= '0;
                end else if (fcnt_q == 4'(FILTER_LEN - 1)) begin
                    filt_q    <= ~filt_q;
                    fcnt_q    <= '0;
                    bit_stb_q <= filt_q;
                end else begin
                    fcnt_q <= fcnt_q + 4'd1;
                end
            end
        end
    end

    assign frame_nx = {dat_sync_q[1], shreg_q[FRAME_BITS-1:1]};
    assign last_bit = bit_stb_q && (bitcnt_q == 4'(FRAME_BITS - 1));
    assign to_evt   = (state_q == SHIFT) && !last_bit && (wdog_q == 16'd1);

    // Check results are registered on the last shift so they are live during CHECK.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bitcnt_q   <= '0;
            shreg_q    <= '0;
            wdog_q     <= '0;
            push_q     <= 1'b0;
            par_fail_q <= 1'b0;
            frm_fail_q <= 1'b0;
        end else begin
            push_q     <= 1'b0;
            par_fail_q <= 1'b0;
            frm_fail_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bit_stb_q && !dat_sync_q[1]) begin
                        state_q  <= SHIFT;
                        bitcnt_q <= '0;
                        wdog_q   <= 16'(TIMEOUT);
                    end
                end
                SHIFT: begin
                    wdog_q <= wdog_q - 16'd1;
                    if (bit_stb_q) begin
                        shreg_q  <= frame_nx;
                        bitcnt_q <= bitcnt_q + 4'd1;
                    end
                    if (last_bit) begin
                        state_q    <= CHECK;
                        frm_fail_q <= ~frame_nx[STOP_BIT];
                        par_fail_q <= ~parity_ok(frame_nx[PAR_BIT:0]);
                        push_q     <= frame_nx[STOP_BIT] & parity_ok(frame_nx[PAR_BIT:0]);
                    end else if (to_evt) begin
                        state_q <= IDLE;
                    end
                end
                CHECK:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    ps2_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (push_q),
        .wdata (shreg_q[7:0]),
        .rd    (rden),
        .rdata (q),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (count)
    );

    always_comb begin
        err_set               = '0;
        err_set[ERR_PARITY]   = par_fail_q;
        err_set[ERR_FRAME]    = frm_fail_q;
        err_set[ERR_TIMEOUT]  = to_evt;
        err_set[ERR_OVERFLOW] = fifo_full & push_q & ~rden;
    end

    // A new event outranks a clear issued in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) err_q <= '0;
        else       err_q <= (clr_err ? '0 : err_q) | err_set;
    end

    assign dsr        = ~fifo_empty;
    assign parity_err = err_q[ERR_PARITY];
    assign frame_err  = err_q[ERR_FRAME];
    assign timeout    = err_q[ERR_TIMEOUT];
    assign overflow   = err_q[ERR_OVERFLOW];

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: table of frames, directed corner sequences, random frames against a queue model.
// Instance a runs normal traffic; instance b shares the pins with a short watchdog.
module tb_ps2_rx_fifo;
    localparam int FL    = 4;
    localparam int DEPTH = 4;
    localparam int H     = 16;
    localparam int TO_A  = 400;
    localparam int TO_B  = 100;

    logic clk = 1'b0, reset = 1'b1, samplen = 1'b1;
    logic ps2_clk = 1'b1, ps2_data = 1'b1, rden = 1'b0, clr_err = 1'b0;
    logic [7:0] q_a, q_b;
    logic [2:0] cnt_a, cnt_b;
    logic dsr_a, pe_a, fe_a, to_a, ov_a;
    logic dsr_b, pe_b, fe_b, to_b, ov_b;

    int errors = 0, checks = 0, cyc = 0, start_c = 0;

    typedef struct {
        logic [7:0] dat;
        logic       bp, bs;
        logic       exp_dsr, exp_pe, exp_fe;
        logic [7:0] exp_q;
    } vec_t;

    always #5 clk = ~clk;

    ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT(TO_A), .FIFO_DEPTH(DEPTH)) dut_a (
        .clk(clk), .reset(reset), .samplen(samplen), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rden(rden), .clr_err(clr_err), .q(q_a), .dsr(dsr_a), .count(cnt_a),
        .parity_err(pe_a), .frame_err(fe_a), .timeout(to_a), .overflow(ov_a));

    ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT(TO_B), .FIFO_DEPTH(DEPTH)) dut_b (
        .clk(clk), .reset(reset), .samplen(samplen), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rden(rden), .clr_err(clr_err), .q(q_b), .dsr(dsr_b), .count(cnt_b),
        .parity_err(pe_b), .frame_err(fe_b), .timeout(to_b), .overflow(ov_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
        logic par;
        par = ~(^d) ^ bad_par;
        return {~bad_stop, par, d, 1'b0};
    endfunction

    // Leaves ps2_clk low on the falling edge of bit n-1; cyc is then that cycle.
    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            repeat (H) tick();
            ps2_clk = 1'b0;
            if (i == 0) start_c = cyc;
            if (i < n - 1) begin
                repeat (H) tick();
                ps2_clk = 1'b1;
            end
        end
    endtask

    task automatic release_clk();
        repeat (H) tick();
        ps2_clk = 1'b1;
        repeat (H) tick();
        ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic bp, input logic bs);
        send_bits(mk_frame(d, bp, bs), 11);
        release_clk();
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    task automatic pop(input logic [7:0] exp, input string nm);
        chk(nm, q_a, exp);
        rden = 1'b1;
        tick();
        rden = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        vec_t       tbl [7];
        logic [7:0] mq [$];
        logic [7:0] d;
        logic       bp, bs, good, mpe, mfe, mov;
        int         e, k;

        tbl[0] = '{8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h1C};
        tbl[1] = '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[2] = '{8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A};
        tbl[3] = '{8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[4] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00};
        tbl[5] = '{8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF};
        tbl[6] = '{8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h80};

        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_q", q_a, 0);       chk("rst_dsr", dsr_a, 0);   chk("rst_count", cnt_a, 0);
        chk("rst_par", pe_a, 0);    chk("rst_frm", fe_a, 0);    chk("rst_to", to_a, 0);
        chk("rst_ovf", ov_a, 0);    chk("rst_b_q", q_b, 0);     chk("rst_b_dsr", dsr_b, 0);
        chk("rst_b_count", cnt_b, 0); chk("rst_b_flags", {pe_b, fe_b, to_b, ov_b}, 0);

        // Reset in mid-frame must discard the partial frame.
        send_bits(mk_frame(8'hAA, 1'b0, 1'b0), 4);
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (2 * H) tick();
        chk("rst_mid_count", cnt_a, 0);

        // Exact latency from the stop-bit falling edge.
        send_bits(mk_frame(8'h1C, 1'b0, 1'b0), 11);
        repeat (7) tick();
        chk("lat_dsr_early", dsr_a, 0);
        tick();
        chk("lat_dsr", dsr_a, 1);   chk("lat_q", q_a, 8'h1C);   chk("lat_count", cnt_a, 1);
        chk("lat_flags", {pe_a, fe_a, to_a, ov_a}, 0);
        release_clk();
        pop(8'h1C, "lat_pop");
        chk("lat_empty", dsr_a, 0);

        rden = 1'b1;
        tick();
        rden = 1'b0;
        chk("pop_empty_count", cnt_a, 0);
        chk("pop_empty_q", q_a, 0);

        for (int i = 0; i < 7; i++) begin
            send_byte(tbl[i].dat, tbl[i].bp, tbl[i].bs);
            chk($sformatf("tbl%0d_dsr", i), dsr_a, tbl[i].exp_dsr);
            chk($sformatf("tbl%0d_q", i), q_a, tbl[i].exp_q);
            chk($sformatf("tbl%0d_count", i), cnt_a, tbl[i].exp_dsr);
            chk($sformatf("tbl%0d_par", i), pe_a, tbl[i].exp_pe);
            chk($sformatf("tbl%0d_frm", i), fe_a, tbl[i].exp_fe);
            if (tbl[i].exp_dsr) pop(tbl[i].exp_q, $sformatf("tbl%0d_pop", i));
            if (tbl[i].exp_pe || tbl[i].exp_fe) begin
                pulse_clr();
                chk($sformatf("tbl%0d_clr", i), {pe_a, fe_a}, 0);
            end
        end

        // A clear in the CHECK cycle loses to the new parity error.
        send_bits(mk_frame(8'h33, 1'b1, 1'b0), 11);
        repeat (7) tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("setwin_par", pe_a, 1);
        release_clk();
        pulse_clr();
        chk("setwin_clr", pe_a, 0);

        // Short low pulses on ps2_clk while data is low must not start a frame.
        ps2_data = 1'b0;
        repeat (4) tick();
        ps2_clk = 1'b0;
        tick();
        ps2_clk = 1'b1;
        repeat (H) tick();
        ps2_clk = 1'b0;
        repeat (FL - 1) tick();
        ps2_clk = 1'b1;
        repeat (H) tick();
        ps2_data = 1'b1;
        repeat (H) tick();
        send_byte(8'hF0, 1'b0, 1'b0);
        chk("glitch_q", q_a, 8'hF0);
        chk("glitch_count", cnt_a, 1);
        chk("glitch_flags", {pe_a, fe_a}, 0);
        pop(8'hF0, "glitch_pop");

        // Stalled frame: watchdog fires TIMEOUT cycles after start acceptance.
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        send_bits(mk_frame(8'h12, 1'b0, 1'b0), 3);
        repeat (H) tick();
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        while (cyc < start_c + 6 + TO_B) tick();
        chk("stall_b_early", to_b, 0);
        tick();
        chk("stall_b_to", to_b, 1);
        chk("stall_a_quiet", to_a, 0);
        while (cyc < start_c + 6 + TO_A) tick();
        chk("stall_a_early", to_a, 0);
        tick();
        chk("stall_a_to", to_a, 1);
        chk("stall_a_count", cnt_a, 0);
        send_byte(8'h12, 1'b0, 1'b0);
        chk("stall_next_q", q_a, 8'h12);
        chk("stall_next_flags", {pe_a, fe_a}, 0);
        pop(8'h12, "stall_next_pop");
        pulse_clr();

        // Fill past depth without popping.
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b0, 1'b0);
        chk("fill_count", cnt_a, 4);
        chk("fill_ovf", ov_a, 1);
        for (int i = 1; i <= 4; i++) pop(8'(i), $sformatf("fill_pop%0d", i));
        chk("fill_drained", dsr_a, 0);
        chk("fill_q_empty", q_a, 0);
        pulse_clr();
        chk("fill_clr", ov_a, 0);

        // Full FIFO with a pop in the CHECK cycle of a good byte.
        for (int i = 0; i < 4; i++) send_byte(8'h21 + 8'(i), 1'b0, 1'b0);
        send_bits(mk_frame(8'h25, 1'b0, 1'b0), 11);
        repeat (7) tick();
        rden = 1'b1;
        tick();
        rden = 1'b0;
        chk("pp_count", cnt_a, 4);
        chk("pp_ovf", ov_a, 0);
        chk("pp_head", q_a, 8'h22);
        release_clk();
        for (int i = 2; i <= 5; i++) pop(8'h20 + 8'(i), $sformatf("pp_pop%0d", i));
        chk("pp_drained", dsr_a, 0);

        // Random frames against a queue model.
        mpe = 1'b0; mfe = 1'b0; mov = 1'b0;
        for (int n = 0; n < 16; n++) begin
            k = $urandom_range(0, mq.size());
            for (int j = 0; j < k; j++) pop(mq.pop_front(), "rnd_pop");
            d  = 8'($urandom);
            e  = $urandom_range(0, 5);
            bp = (e == 1) || (e == 3);
            bs = (e == 2) || (e == 3);
            good = !bp && !bs;
            send_byte(d, bp, bs);
            if (bp) mpe = 1'b1;
            if (bs) mfe = 1'b1;
            if (good) begin
                if (mq.size() < DEPTH) mq.push_back(d);
                else mov = 1'b1;
            end
            chk("rnd_count", cnt_a, mq.size());
            chk("rnd_dsr", dsr_a, mq.size() != 0);
            chk("rnd_q", q_a, (mq.size() != 0) ? mq[0] : 8'h00);
            chk("rnd_flags", {pe_a, fe_a, to_a, ov_a}, {mpe, mfe, 1'b0, mov});
            if ($urandom_range(0, 3) == 0) begin
                pulse_clr();
                mpe = 1'b0; mfe = 1'b0; mov = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
